// File: rtl/serv_rf_arb_pkg.sv
// Shared types and helpers for the SERV register-file RAM arbiter.
// State encoding, register count and beats-per-word helper.
package serv_rf_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        ACK   = 3'd3,
        CLEAR = 3'd4
    } state_t;

    localparam int GPRS = 32;

    // Architectural registers held in the RAM: 32 GPRs followed by the CSRs.
    function automatic int NREGS(input int csr_regs);
        return GPRS + csr_regs;
    endfunction

    // RAM beats needed to move one 32-bit debug word.
    function automatic int BEATS(input int width);
        return 32 / width;
    endfunction

endpackage

// File: rtl/serv_rf_dbg_gather.sv
// Reassembles a 32-bit debug read word from width-bit RAM beats, LSB chunk first.
// The beat issued in one cycle is captured from the RAM output in the next.
module serv_rf_dbg_gather
    import serv_rf_arb_pkg::*;
#(
    parameter int width = 8,
    parameter int iw    = (BEATS(width) > 1) ? $clog2(BEATS(width)) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_issue,
    input  logic [iw-1:0]    i_idx,
    input  logic [width-1:0] i_rdata,
    output logic             o_cap,
    output logic [iw-1:0]    o_cap_idx,
    output logic [31:0]      o_word
);

    logic          pending;
    logic [iw-1:0] pidx;
    logic [31:0]   word_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= 1'b0;
            pidx    <= '0;
            word_q  <= '0;
        end else begin
            pending <= i_issue;
            if (i_issue)
                pidx <= i_idx;
            if (pending)
                word_q[pidx*width +: width] <= i_rdata;
        end
    end

    // Merged view lets the last chunk be committed in the same cycle it arrives.
    always_comb begin
        o_word = word_q;
        if (pending)
            o_word[pidx*width +: width] = i_rdata;
    end

    assign o_cap     = pending;
    assign o_cap_idx = pidx;

endmodule

// File: rtl/serv_rf_ram_arb.sv
// Arbitrates the SERV register-file RAM between the core (absolute priority) and a 32-bit debug port.
// Optional power-on RAM clear is enabled by defining SERV_RF_CLEAR_EN.
module serv_rf_ram_arb
    import serv_rf_arb_pkg::*;
#(
    parameter int width    = 8,
    parameter int csr_regs = 4,
    parameter int depth    = 32 * (32 + csr_regs) / width,
    parameter int aw       = $clog2(depth)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [aw-1:0]    i_c_waddr,
    input  logic [width-1:0] i_c_wdata,
    input  logic             i_c_wen,
    input  logic [aw-1:0]    i_c_raddr,
    input  logic             i_c_ren,
    output logic [width-1:0] o_c_rdata,
    output logic             o_c_ready,
    output logic [aw-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw-1:0]    o_raddr,
    input  logic [width-1:0] i_rdata,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [5:0]       i_dbg_reg,
    input  logic [31:0]      i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic             o_dbg_err,
    output logic [31:0]      o_dbg_rdata,
    output logic             o_init_done
);

    localparam int N  = BEATS(width);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

`ifdef SERV_RF_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    beat;
    logic [IW-1:0]    beat_idx;
    logic             c_wen;
    logic             c_ren;
    logic             bad_reg;
    logic             wr_issue;
    logic             rd_issue;
    logic             beat_last;
    logic             cap;
    logic [IW-1:0]    cap_idx;
    logic             cap_last;
    logic [31:0]      gather_word;
    logic [aw-1:0]    dbg_addr;
    logic [width-1:0] dbg_wchunk;
    logic             err_q;
    logic [31:0]      rdata_q;

`ifdef SERV_RF_CLEAR_EN
    logic [aw-1:0] clr_addr;
    logic          clr_last;
    logic          init_q;

    assign clr_last    = (clr_addr == aw'(depth - 1));
    assign o_c_ready   = (state != CLEAR);
    assign o_init_done = init_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clr_addr <= '0;
            init_q   <= 1'b0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_last ? '0 : clr_addr + aw'(1);
            if (clr_last)
                init_q <= 1'b1;
        end
    end
`else
    assign o_c_ready   = 1'b1;
    assign o_init_done = 1'b1;
`endif

    // Core strobes are masked while the RAM is being cleared.
    assign c_wen = i_c_wen & o_c_ready;
    assign c_ren = i_c_ren & o_c_ready;

    assign bad_reg    = int'(i_dbg_reg) >= NREGS(csr_regs);
    assign beat_idx   = beat[IW-1:0];
    assign beat_last  = (beat == CW'(N - 1));
    assign dbg_addr   = aw'(int'(i_dbg_reg) * N + int'(beat));
    assign dbg_wchunk = i_dbg_wdata[beat_idx*width +: width];

    assign wr_issue = (state == WR) && !c_wen;
    assign rd_issue = (state == RD) && !c_ren && (beat < CW'(N));
    assign cap_last = (state == RD) && cap && (cap_idx == IW'(N - 1));

    serv_rf_dbg_gather #(
        .width (width),
        .iw    (IW)
    ) u_gather (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_issue   (rd_issue),
        .i_idx     (beat_idx),
        .i_rdata   (i_rdata),
        .o_cap     (cap),
        .o_cap_idx (cap_idx),
        .o_word    (gather_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_dbg_req) begin
                    if (bad_reg)
                        state_nxt = ACK;
                    else if (i_dbg_we)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            WR:  if (wr_issue && beat_last) state_nxt = ACK;
            RD:  if (cap_last) state_nxt = ACK;
            ACK: state_nxt = IDLE;
`ifdef SERV_RF_CLEAR_EN
            CLEAR: if (clr_last) state_nxt = IDLE;
`else
            CLEAR: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_nxt == ACK)
                beat <= '0;
            else if (wr_issue || rd_issue)
                beat <= beat + CW'(1);
            err_q <= (state == IDLE) && i_dbg_req && bad_reg;
            if (cap_last)
                rdata_q <= gather_word;
        end
    end

    // Write port: clear beats, then core, then debug; x0 beats are counted but never written.
    always_comb begin
        o_wen   = 1'b0;
        o_waddr = dbg_addr;
        o_wdata = dbg_wchunk;
        if (c_wen) begin
            o_wen   = 1'b1;
            o_waddr = i_c_waddr;
            o_wdata = i_c_wdata;
        end else if (wr_issue) begin
            o_wen = (i_dbg_reg != 6'd0);
        end
`ifdef SERV_RF_CLEAR_EN
        if (state == CLEAR) begin
            o_wen   = 1'b1;
            o_waddr = clr_addr;
            o_wdata = '0;
        end
`endif
    end

    assign o_raddr     = c_ren ? i_c_raddr : ((state == RD) ? dbg_addr : '0);
    assign o_c_rdata   = i_rdata;
    assign o_dbg_ack   = (state == ACK);
    assign o_dbg_err   = err_q;
    assign o_dbg_rdata = rdata_q;

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// Self-checking bench for serv_rf_ram_arb (width=8, csr_regs=4) with a behavioural RAM model.
// Covers the SERV_RF_CLEAR_EN build as well when that macro is defined.
`timescale 1ns/1ps
module tb_serv_rf_ram_arb;

    localparam int W     = 8;
    localparam int CSR   = 4;
    localparam int DEPTH = 144;
    localparam int AW    = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [7:0]    cyc;
    } wr_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [AW-1:0] i_c_waddr = '0;
    logic [W-1:0]  i_c_wdata = '0;
    logic          i_c_wen = 1'b0;
    logic [AW-1:0] i_c_raddr = '0;
    logic          i_c_ren = 1'b0;
    logic [W-1:0]  o_c_rdata;
    logic          o_c_ready;
    logic [AW-1:0] o_waddr;
    logic [W-1:0]  o_wdata;
    logic          o_wen;
    logic [AW-1:0] o_raddr;
    logic [W-1:0]  i_rdata = '0;
    logic          i_dbg_req = 1'b0;
    logic          i_dbg_we = 1'b0;
    logic [5:0]    i_dbg_reg = '0;
    logic [31:0]   i_dbg_wdata = '0;
    logic          o_dbg_ack;
    logic          o_dbg_err;
    logic [31:0]   o_dbg_rdata;
    logic          o_init_done;

    int            n_cmp = 0;
    int            n_bad = 0;
    wr_t           exp_wr[$];
    wr_t           obs_wr[$];
    logic [31:0]   exp_rd[$];
    int            ack_cyc;
    logic          ack_err;
    logic [31:0]   ack_rdata;
    logic [AW-1:0] raddr_log[32];
    logic [W-1:0]  crd_log[32];
    logic [W-1:0]  mem[DEPTH];

    always #5 i_clk = ~i_clk;

    serv_rf_ram_arb #(.width(W), .csr_regs(CSR)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_c_waddr   (i_c_waddr),
        .i_c_wdata   (i_c_wdata),
        .i_c_wen     (i_c_wen),
        .i_c_raddr   (i_c_raddr),
        .i_c_ren     (i_c_ren),
        .o_c_rdata   (o_c_rdata),
        .o_c_ready   (o_c_ready),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_wen       (o_wen),
        .o_raddr     (o_raddr),
        .i_rdata     (i_rdata),
        .i_dbg_req   (i_dbg_req),
        .i_dbg_we    (i_dbg_we),
        .i_dbg_reg   (i_dbg_reg),
        .i_dbg_wdata (i_dbg_wdata),
        .o_dbg_ack   (o_dbg_ack),
        .o_dbg_err   (o_dbg_err),
        .o_dbg_rdata (o_dbg_rdata),
        .o_init_done (o_init_done)
    );

    // RAM model: registered read, x0 (addresses 0..3) reads as zero.
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge i_clk) begin
        if (o_wen && o_waddr < AW'(DEPTH)) mem[o_waddr] <= o_wdata;
        i_rdata <= (o_raddr < 8'd4 || o_raddr >= AW'(DEPTH)) ? '0 : mem[o_raddr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Drives one debug request and records what the DUT does, cycle by cycle, until ack.
    task automatic run_dbg(input logic we, input logic [5:0] r, input logic [31:0] wd,
                           input logic [31:0] ren_mask, input logic [31:0] wen_mask,
                           input logic [AW-1:0] c_addr, input logic [W-1:0] c_data);
        obs_wr.delete();
        ack_cyc = -1;
        ack_err = 1'b0;
        ack_rdata = '0;
        i_dbg_req = 1'b1;
        i_dbg_we = we;
        i_dbg_reg = r;
        i_dbg_wdata = wd;
        i_c_waddr = c_addr;
        i_c_wdata = c_data;
        i_c_raddr = c_addr;
        for (int n = 0; n < 32; n++) begin
            i_c_ren = ren_mask[n];
            i_c_wen = wen_mask[n];
            @(negedge i_clk);
            raddr_log[n] = o_raddr;
            crd_log[n] = o_c_rdata;
            if (o_wen) obs_wr.push_back('{o_waddr, o_wdata, 8'(n)});
            if (o_dbg_ack) begin
                ack_cyc = n;
                ack_err = o_dbg_err;
                ack_rdata = o_dbg_rdata;
            end
            @(posedge i_clk); #1;
            if (ack_cyc >= 0) break;
        end
        i_dbg_req = 1'b0;
        i_c_ren = 1'b0;
        i_c_wen = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset;
        logic exp_wen, exp_init;
`ifdef SERV_RF_CLEAR_EN
        exp_wen = 1'b1; exp_init = 1'b0;
`else
        exp_wen = 1'b0; exp_init = 1'b1;
`endif
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_cmp++; if (o_dbg_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", o_dbg_ack); end
        n_cmp++; if (o_dbg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_dbg_err); end
        n_cmp++; if (o_dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", o_dbg_rdata); end
        n_cmp++; if (o_wen !== exp_wen) begin n_bad++; $display("FAIL reset_wen: got %b want %b", o_wen, exp_wen); end
        n_cmp++; if (o_init_done !== exp_init) begin n_bad++; $display("FAIL reset_init: got %b want %b", o_init_done, exp_init); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 400 && o_init_done !== 1'b1; i++) begin
            @(posedge i_clk); #1;
        end
        n_cmp++; if (o_init_done !== 1'b1) begin n_bad++; $display("FAIL reset_init_wait: got %b want 1", o_init_done); end
        n_cmp++; if (o_c_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_c_ready); end
    endtask

    task automatic test_write_read;
        wr_t e, o;
        logic [31:0] er;
        exp_wr.push_back('{8'd20, 8'hEF, 8'd1});
        exp_wr.push_back('{8'd21, 8'hBE, 8'd2});
        exp_wr.push_back('{8'd22, 8'hAD, 8'd3});
        exp_wr.push_back('{8'd23, 8'hDE, 8'd4});
        run_dbg(1'b1, 6'd5, 32'hDEADBEEF, '0, '0, '0, '0);
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL wr5_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL wr5_beat: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
        end
        exp_wr.delete();
        n_cmp++; if (ack_cyc != 5) begin n_bad++; $display("FAIL wr5_ack_cycle: got %0d want 5", ack_cyc); end
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL wr5_err: got %b want 0", ack_err); end

        exp_rd.push_back(32'hDEADBEEF);
        run_dbg(1'b0, 6'd5, '0, '0, '0, '0, '0);
        er = exp_rd.pop_front();
        n_cmp++; if (ack_rdata !== er) begin n_bad++; $display("FAIL rd5_data: got %h want %h", ack_rdata, er); end
        n_cmp++; if (ack_cyc != 6) begin n_bad++; $display("FAIL rd5_ack_cycle: got %0d want 6", ack_cyc); end
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL rd5_err: got %b want 0", ack_err); end
        n_cmp++; if (obs_wr.size() != 0) begin n_bad++; $display("FAIL rd5_no_write: got %0d writes want 0", obs_wr.size()); end
    endtask

    task automatic test_read_contention;
        logic [31:0] er;
        run_dbg(1'b1, 6'd7, 32'h0A0B0C0D, '0, '0, '0, '0);
        exp_rd.push_back(32'hDEADBEEF);
        run_dbg(1'b0, 6'd5, '0, 32'h0000_000A, '0, 8'd29, '0);
        er = exp_rd.pop_front();
        n_cmp++; if (ack_rdata !== er) begin n_bad++; $display("FAIL rdc_data: got %h want %h", ack_rdata, er); end
        n_cmp++; if (ack_cyc != 8) begin n_bad++; $display("FAIL rdc_ack_cycle: got %0d want 8", ack_cyc); end
        n_cmp++; if (raddr_log[1] !== 8'd29 || raddr_log[3] !== 8'd29) begin n_bad++; $display("FAIL rdc_core_raddr: got %0d,%0d want 29,29", raddr_log[1], raddr_log[3]); end
        n_cmp++; if (raddr_log[2] !== 8'd20) begin n_bad++; $display("FAIL rdc_dbg_raddr: got %0d want 20", raddr_log[2]); end
        n_cmp++; if (crd_log[2] !== 8'h0C || crd_log[4] !== 8'h0C) begin n_bad++; $display("FAIL rdc_core_rdata: got %h,%h want 0c,0c", crd_log[2], crd_log[4]); end
    endtask

    task automatic test_core_priority;
        wr_t e, o;
        exp_wr.push_back('{8'd100, 8'h5A, 8'd1});
        exp_wr.push_back('{8'd100, 8'h5A, 8'd2});
        exp_wr.push_back('{8'd24, 8'h11, 8'd3});
        exp_wr.push_back('{8'd25, 8'h22, 8'd4});
        exp_wr.push_back('{8'd26, 8'h33, 8'd5});
        exp_wr.push_back('{8'd27, 8'h44, 8'd6});
        run_dbg(1'b1, 6'd6, 32'h44332211, '0, 32'h0000_0006, 8'd100, 8'h5A);
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL prio_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL prio_beat: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
        end
        exp_wr.delete();
        n_cmp++; if (ack_cyc != 7) begin n_bad++; $display("FAIL prio_ack_cycle: got %0d want 7", ack_cyc); end
    endtask

    task automatic test_x0;
        logic [31:0] er;
        run_dbg(1'b1, 6'd0, 32'h12345678, '0, '0, '0, '0);
        n_cmp++; if (obs_wr.size() != 0) begin n_bad++; $display("FAIL x0_no_write: got %0d writes want 0", obs_wr.size()); end
        n_cmp++; if (ack_cyc != 5) begin n_bad++; $display("FAIL x0_wr_ack_cycle: got %0d want 5", ack_cyc); end
        exp_rd.push_back(32'h0);
        run_dbg(1'b0, 6'd0, '0, '0, '0, '0, '0);
        er = exp_rd.pop_front();
        n_cmp++; if (ack_rdata !== er) begin n_bad++; $display("FAIL x0_rdata: got %h want %h", ack_rdata, er); end
    endtask

    task automatic test_bad_reg;
        wr_t e, o;
        logic [31:0] er;
        exp_rd.push_back(32'hDEADBEEF);
        run_dbg(1'b0, 6'd5, '0, '0, '0, '0, '0);
        er = exp_rd.pop_front();
        n_cmp++; if (ack_rdata !== er) begin n_bad++; $display("FAIL bad_pre_read: got %h want %h", ack_rdata, er); end

        run_dbg(1'b1, 6'd36, 32'hFFFFFFFF, '0, '0, '0, '0);
        n_cmp++; if (ack_cyc != 1) begin n_bad++; $display("FAIL bad36_ack_cycle: got %0d want 1", ack_cyc); end
        n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL bad36_err: got %b want 1", ack_err); end
        n_cmp++; if (obs_wr.size() != 0) begin n_bad++; $display("FAIL bad36_no_write: got %0d writes want 0", obs_wr.size()); end
        n_cmp++; if (raddr_log[0] !== 8'd0 || raddr_log[1] !== 8'd0) begin n_bad++; $display("FAIL bad36_raddr: got %0d,%0d want 0,0", raddr_log[0], raddr_log[1]); end

        run_dbg(1'b0, 6'd63, '0, '0, '0, '0, '0);
        n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL bad63_err: got %b want 1", ack_err); end
        n_cmp++; if (ack_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bad63_rdata_held: got %h want deadbeef", ack_rdata); end

        exp_wr.push_back('{8'd140, 8'h0D, 8'd1});
        exp_wr.push_back('{8'd141, 8'hF0, 8'd2});
        exp_wr.push_back('{8'd142, 8'hFE, 8'd3});
        exp_wr.push_back('{8'd143, 8'hCA, 8'd4});
        run_dbg(1'b1, 6'd35, 32'hCAFEF00D, '0, '0, '0, '0);
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL r35_err: got %b want 0", ack_err); end
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL r35_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL r35_beat: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc); end
        end
        exp_wr.delete();
        exp_rd.push_back(32'hCAFEF00D);
        run_dbg(1'b0, 6'd35, '0, '0, '0, '0, '0);
        er = exp_rd.pop_front();
        n_cmp++; if (ack_rdata !== er) begin n_bad++; $display("FAIL r35_rdata: got %h want %h", ack_rdata, er); end
    endtask

    task automatic test_reset_midop;
        logic [31:0] er;
`ifdef SERV_RF_CLEAR_EN
        er = 32'h0;
`else
        er = 32'h00003344;
`endif
        i_dbg_req = 1'b1;
        i_dbg_we = 1'b1;
        i_dbg_reg = 6'd9;
        i_dbg_wdata = 32'h11223344;
        repeat (3) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        n_cmp++; if (o_wen !== 1'b1 || o_waddr !== 8'd38) begin n_bad++; $display("FAIL midop_beat2: got wen=%b a=%0d want wen=1 a=38", o_wen, o_waddr); end
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_dbg_ack !== 1'b0) begin n_bad++; $display("FAIL midop_ack: got %b want 0", o_dbg_ack); end
        n_cmp++; if (o_dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL midop_rdata_reset: got %h want 0", o_dbg_rdata); end
        @(posedge i_clk); #1;
        i_dbg_req = 1'b0;
        i_rst_n = 1'b1;
        for (int i = 0; i < 400 && o_init_done !== 1'b1; i++) begin
            @(posedge i_clk); #1;
        end
        n_cmp++; if (o_init_done !== 1'b1) begin n_bad++; $display("FAIL midop_init: got %b want 1", o_init_done); end
        exp_rd.push_back(er);
        run_dbg(1'b0, 6'd9, '0, '0, '0, '0, '0);
        er = exp_rd.pop_front();
        n_cmp++; if (ack_rdata !== er) begin n_bad++; $display("FAIL midop_readback: got %h want %h", ack_rdata, er); end
    endtask

`ifdef SERV_RF_CLEAR_EN
    task automatic test_clear;
        int bad_cyc;
        logic [31:0] er;
        // Restart case: abort a clear 50 cycles in, then run a full one.
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (50) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        bad_cyc = 0;
        for (int c = 1; c <= 145; c++) begin
            i_c_wen = (c <= 144);
            i_c_waddr = 8'd77;
            i_c_wdata = 8'hFF;
            @(negedge i_clk);
            if (c <= 144) begin
                if ((o_wen !== 1'b1 || o_waddr !== AW'(c - 1) || o_wdata !== 8'h00 ||
                     o_c_ready !== 1'b0 || o_init_done !== 1'b0) && bad_cyc == 0)
                    bad_cyc = c;
            end else begin
                n_cmp++; if (o_init_done !== 1'b1) begin n_bad++; $display("FAIL clear_init_145: got %b want 1", o_init_done); end
                n_cmp++; if (o_c_ready !== 1'b1) begin n_bad++; $display("FAIL clear_ready_145: got %b want 1", o_c_ready); end
            end
            @(posedge i_clk); #1;
        end
        i_c_wen = 1'b0;
        n_cmp++; if (bad_cyc != 0) begin n_bad++; $display("FAIL clear_seq: first bad cycle %0d want none", bad_cyc); end
        exp_rd.push_back(32'h0);
        run_dbg(1'b0, 6'd5, '0, '0, '0, '0, '0);
        er = exp_rd.pop_front();
        n_cmp++; if (ack_rdata !== er) begin n_bad++; $display("FAIL clear_readback: got %h want %h", ack_rdata, er); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_read_contention();
        test_core_priority();
        test_x0();
        test_bad_reg();
        test_reset_midop();
`ifdef SERV_RF_CLEAR_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
